// File: rtl/btn_debouncer_pkg.sv
// Shared definitions for the push-button debouncer: per-channel FSM state
// encodings and a small helper that maps a state to the debounced level.
package btn_debouncer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMING    = 2'd1,
    ST_PRESSED   = 2'd2,
    ST_RELEASING = 2'd3
  } btn_state_e;

  // The button counts as "down" once a press has been accepted and until
  // the release has been confirmed.
  function automatic logic state_is_down(input btn_state_e st);
    return (st == ST_PRESSED) || (st == ST_RELEASING);
  endfunction

endpackage

// File: rtl/btn_debouncer_ch.sv
// One debounced push-button channel: two-flop synchronizer, stability
// counter, four-state press/release FSM and a registered press pulse.
module btn_debounce_ch
  import btn_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int NB_CNT          = 20
) (
  input  logic clock,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_pulse,
  output logic o_level
);

  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(DEBOUNCE_CYCLES - 1);

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  btn_state_e        state_q, state_d;
  logic [NB_CNT-1:0] cnt_q,   cnt_d;
  logic              pulse_q, pulse_d;

  // Synchronizer chain: the raw button is asynchronous to clock.
  always_comb begin
    sync1_d = i_btn;
    sync2_d = sync1_q;
  end

  // Next-state logic; the counter only advances while a level change is
  // being qualified, so it never wraps in the stable IDLE/PRESSED states.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sync2_q) begin
          state_d = ST_ARMING;
          cnt_d   = '0;
        end
      end
      ST_ARMING: begin
        if (!sync2_q) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_PRESSED;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!sync2_q) begin
          state_d = ST_RELEASING;
          cnt_d   = '0;
        end
      end
      ST_RELEASING: begin
        if (sync2_q) begin
          // Release glitch: fall back to PRESSED without a new pulse.
          state_d = ST_PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, synchronizer and pulse registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign o_pulse = pulse_q;
  assign o_level = state_is_down(state_q);

endmodule

// File: rtl/btn_debouncer.sv
// Multi-channel push-button debouncer: NB_BTN independent channels, each
// producing a debounced level and a single-cycle pulse per accepted press.
module btn_debouncer
  import btn_debouncer_pkg::*;
#(
  parameter int NB_BTN          = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int NB_CNT          = 20
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic [NB_BTN-1:0] i_btn,
  output logic [NB_BTN-1:0] o_btn_pulse,
  output logic [NB_BTN-1:0] o_btn_level
);

  // One fully independent channel per button bit.
  for (genvar i = 0; i < NB_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .NB_CNT          (NB_CNT)
    ) u_ch (
      .clock   (clock),
      .i_reset (i_reset),
      .i_btn   (i_btn[i]),
      .o_pulse (o_btn_pulse[i]),
      .o_level (o_btn_level[i])
    );
  end

endmodule

// File: tb/tb_btn_debouncer.sv
// Directed bench for btn_debouncer with DEBOUNCE_CYCLES=4, NB_BTN=3.
// Expected pulses are queued (absolute edge number + vector) when the
// stimulus that causes them is applied; every cycle the pulse output is
// compared against the head of the queue (or zero when nothing is due).
module tb_btn_debouncer;
  import btn_debouncer_pkg::*;

  localparam int NB   = 3;
  localparam int DC   = 4;
  localparam int LAT  = DC + 3;

  typedef struct {
    int          cyc;
    logic [NB-1:0] vec;
  } exp_pulse_t;

  logic          clock;
  logic          i_reset;
  logic [NB-1:0] i_btn;
  logic [NB-1:0] o_btn_pulse;
  logic [NB-1:0] o_btn_level;

  exp_pulse_t sb[$];
  int cyc;
  int vectors;
  int miscompares;

  btn_debouncer #(
    .NB_BTN          (NB),
    .DEBOUNCE_CYCLES (DC),
    .NB_CNT          (4)
  ) u_dut (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_btn       (i_btn),
    .o_btn_pulse (o_btn_pulse),
    .o_btn_level (o_btn_level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s at edge %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic expect_pulse(input int at_cyc, input logic [NB-1:0] vec);
    exp_pulse_t e;
    e.cyc = at_cyc;
    e.vec = vec;
    sb.push_back(e);
  endtask

  // Advance one clock edge and compare the pulse output with the scoreboard.
  task automatic step();
    logic [NB-1:0] exp;
    @(posedge clock);
    cyc++;
    #1;
    exp = '0;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      exp = sb[0].vec;
      void'(sb.pop_front());
    end
    check("pulse", o_btn_pulse, exp);
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    cyc         = 0;
    vectors     = 0;
    miscompares = 0;
    i_reset     = 1'b1;
    i_btn       = '0;

    // Reset state
    steps(3);
    check("reset_level", o_btn_level, 3'b000);
    i_reset = 1'b0;
    steps(2);

    // Clean press on channel 0, hold, then release
    i_btn = 3'b001;
    expect_pulse(cyc + LAT, 3'b001);
    steps(LAT - 1);
    check("clean_level_pre", o_btn_level, 3'b000);
    step();
    check("clean_level_on", o_btn_level, 3'b001);
    steps(20);
    check("clean_level_held", o_btn_level, 3'b001);
    i_btn = 3'b000;
    steps(LAT - 1);
    check("release_level_pre", o_btn_level, 3'b001);
    step();
    check("release_level_off", o_btn_level, 3'b000);
    steps(3);

    // Bouncing press on channel 1: 3 high, 1 low, then steady high
    i_btn = 3'b010;
    steps(3);
    i_btn = 3'b000;
    step();
    i_btn = 3'b010;
    expect_pulse(cyc + LAT, 3'b010);
    for (int k = 0; k < LAT - 1; k++) begin
      step();
      check("bounce_level_pre", o_btn_level, 3'b000);
    end
    step();
    check("bounce_level_on", o_btn_level, 3'b010);
    i_btn = 3'b000;
    steps(LAT + 2);
    check("bounce_release", o_btn_level, 3'b000);

    // Release glitch on channel 2 while pressed
    i_btn = 3'b100;
    expect_pulse(cyc + LAT, 3'b100);
    steps(LAT);
    check("glitch_level_on", o_btn_level, 3'b100);
    steps(3);
    i_btn = 3'b000;
    steps(2);
    i_btn = 3'b100;
    for (int k = 0; k < 10; k++) begin
      step();
      check("glitch_level_held", o_btn_level, 3'b100);
    end
    i_btn = 3'b000;
    steps(LAT + 2);
    check("glitch_release", o_btn_level, 3'b000);

    // Simultaneous press on all channels
    i_btn = 3'b111;
    expect_pulse(cyc + LAT, 3'b111);
    steps(LAT - 1);
    check("simul_level_pre", o_btn_level, 3'b000);
    step();
    check("simul_level_on", o_btn_level, 3'b111);
    steps(5);
    i_btn = 3'b000;
    steps(LAT + 2);
    check("simul_release", o_btn_level, 3'b000);

    // Reset while channel 0 is arming, button kept held across reset
    i_btn = 3'b001;
    steps(4);
    i_reset = 1'b1;
    steps(2);
    check("rst_arm_level", o_btn_level, 3'b000);
    i_reset = 1'b0;
    expect_pulse(cyc + LAT, 3'b001);
    steps(LAT - 1);
    check("rst_rearm_pre", o_btn_level, 3'b000);
    step();
    check("rst_rearm_on", o_btn_level, 3'b001);
    steps(10);
    i_btn = 3'b000;
    steps(LAT + 2);
    check("rst_rearm_release", o_btn_level, 3'b000);

    // Every queued pulse must have been consumed
    vectors++;
    assert (sb.size() == 0) else begin
      miscompares++;
      $error("FAIL sb_drain: observed %0d pending pulses expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/btn_debouncer.md
BTN_DEBOUNCER -- requirements
Module: btn_debouncer

Interface
REQ-001 Parameter NB_BTN, default 3, number of independent push-button channels; it SHALL match topv2 NB_BTN.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000, number of consecutive stable synchronized samples required to accept a level change; legal range 2 to 2^NB_CNT.
REQ-003 Parameter NB_CNT, default 20, debounce counter width in bits.
REQ-004 Port clock, input, 1 bit: single system clock; all logic SHALL be on its rising edge.
REQ-005 Port i_reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 Port i_btn, input, NB_BTN bits: raw asynchronous bouncing button levels, 1 = pressed.
REQ-007 Port o_btn_pulse, output, NB_BTN bits: one-clock pulse per accepted press; drives topv2 i_btn directly.
REQ-008 Port o_btn_level, output, NB_BTN bits: debounced button level, 1 = pressed.

Function
REQ-009 Each bit of i_btn SHALL pass through a two-flop synchronizer; its second-stage output is s[i].
REQ-010 Each channel SHALL run an independent four-state FSM: IDLE, ARMING, PRESSED, RELEASING.
REQ-011 IDLE: if s=1, go to ARMING with cnt=0; otherwise stay.
REQ-012 ARMING: if s=0, go to IDLE (glitch rejected, no pulse); else if cnt==DEBOUNCE_CYCLES-1, go to PRESSED; else cnt+1.
REQ-013 PRESSED: if s=0, go to RELEASING with cnt=0; otherwise stay.
REQ-014 RELEASING: if s=1, go to PRESSED (release glitch rejected, no new pulse); else if cnt==DEBOUNCE_CYCLES-1, go to IDLE; else cnt+1.
REQ-015 o_btn_pulse[i] SHALL be registered and high for exactly the one cycle in which channel i's state first reads PRESSED after ARMING; a return from RELEASING to PRESSED SHALL NOT pulse.
REQ-016 o_btn_level[i] SHALL be 1 in PRESSED and RELEASING, and 0 in IDLE and ARMING.
REQ-017 Latency: with i_btn[i] held high from rising edge E1, o_btn_pulse[i] SHALL be high in the cycle after edge E1+DEBOUNCE_CYCLES+2 (edges counted inclusive, i.e. the DEBOUNCE_CYCLES+3rd edge).
REQ-018 Release latency SHALL be symmetric: o_btn_level falls DEBOUNCE_CYCLES+3 edges after i_btn goes low.
REQ-019 A press held indefinitely SHALL produce exactly one pulse; the counter SHALL NOT wrap while in PRESSED or IDLE.
REQ-020 Channels SHALL be fully independent; simultaneous presses on several channels SHALL pulse in the same cycle.

Reset
REQ-021 While i_reset=1 at a clock edge: synchronizer flops 0, all FSMs IDLE, cnt 0, o_btn_pulse 0, o_btn_level 0.
REQ-022 Reset asserted mid-ARMING or mid-PRESSED SHALL abort with no pulse; a button still held after reset release SHALL be debounced afresh and pulse once.

Structure
REQ-023 The FSM state encodings (IDLE=2'd0, ARMING=2'd1, PRESSED=2'd2, RELEASING=2'd3) SHALL live in a shared package/header used by the RTL and the bench.
REQ-024 One sub-module, btn_debounce_ch (synchronizer, counter, FSM, and pulse for one bit), SHALL be instantiated NB_BTN times via a generate loop.

Verification (DEBOUNCE_CYCLES=4, NB_BTN=3, 10 ns clock)
REQ-025 Clean press: i_btn=3'b001 held -> o_btn_pulse=3'b001 for one cycle in the cycle after the 7th edge; o_btn_level[0]=1 thereafter; no further pulse while held.
REQ-026 Bounce: i_btn[1] high for 3 cycles, low for 1, then high steady -> no pulse during the bounce; exactly one pulse, 7 edges after the final rise.
REQ-027 Release glitch: while PRESSED, drop i_btn[2] for 2 cycles, then restore -> o_btn_level[2] stays 1 and no second pulse.
REQ-028 Simultaneous: i_btn 3'b000 -> 3'b111 -> o_btn_pulse=3'b111 in a single cycle.
REQ-029 Reset mid-operation: assert i_reset while channel 0 is in ARMING -> no pulse, outputs 0; with the button still held after reset release -> one pulse 7 edges after release.
REQ-030 Integration: chain btn_debouncer into topv2 and replay the A/B/op load sequence (sw=6'b000100 with btn0, sw=6'b001111 with btn1, sw=6'b100000 with btn2) using bouncing buttons -> o_led equals the ADD result 6'b010011.
